data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the multicycle core's data/instruction port A. It accepts the control FSM's level-held port-A strobes (enable, write-enable, address, write data), decodes RAM versus memory-mapped I/O, and drives a synchronous block RAM. It hosts a small I/O register set (LEDs, synchronized switches, cycle counter) and returns read data with a completion pulse. It sits between the control/datapath and the block RAM, replacing the direct RAM hookup.

## Interface
- `RAM_ADDR_WIDTH`, 10: block RAM address bits; RAM address = `memAddr[RAM_ADDR_WIDTH-1:0]`.
- `IO_BASE`, 16'hFF00: addresses >= IO_BASE are I/O; below are RAM.
- `IO_WAIT`, 2: extra wait cycles for I/O accesses (legal range 0..15).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memAEnabled` in 1: access request, level, held by initiator.
- `memAWriteEnabled` in 1: 1 = write, 0 = read; qualified by memAEnabled.
- `memAddr` in 16: word address.
- `memWriteData` in 16: write data.
- `memReadData` out 16: registered read data.
- `memReady` out 1: one-cycle completion pulse.
- `ramEnable`, `ramWriteEnable` out 1 each: block RAM strobes.
- `ramAddr` out RAM_ADDR_WIDTH; `ramWriteData` out 16.
- `ramReadData` in 16: valid one cycle after ramEnable with ramWriteEnable=0.
- `switches` in 16: asynchronous board inputs.
- `leds` out 16: LED register.
- `ioError` out 1: sticky; set on a write to an unmapped or read-only I/O offset.

## Operation
- FSM states: IDLE, RAM_ACC, IO_WAIT, DONE, HOLD.
- IDLE: when memAEnabled=1, accept the request and capture addr/we/data.
  - RAM region: drive ramEnable=1, ramWriteEnable=we, ramAddr, and ramWriteData combinationally in the same cycle; go to RAM_ACC.
  - I/O region: load the wait counter with IO_WAIT; go to IO_WAIT.
- RAM_ACC: on a read, register `ramReadData` into memReadData; go to DONE.
- IO_WAIT: decrement; at 0, perform the I/O read or write and register the read result; go to DONE.
- DONE: memReady=1 for exactly this cycle; go to HOLD.
- HOLD: memReadData held; no new access.
  - memAEnabled=0 -> IDLE.
  - memAEnabled=1 with memAddr or memAWriteEnabled differing from the captured value -> IDLE; the new request is accepted next cycle.
  - Otherwise stay. Each accepted write is performed exactly once.
- I/O map (offset from IO_BASE):
  - 0: LEDs, R/W.
  - 1: switches, RO, 2-flop synchronized.
  - 2: cycle counter, RO; any write clears it to 0.
  - Other offsets read 0; writes to them, and to offset 1, set ioError.
- Cycle counter: 16-bit, increments every cycle, wraps 16'hFFFF -> 0. A clear and an increment in the same cycle -> 0.
- RAM addresses below IO_BASE but >= 2^RAM_ADDR_WIDTH alias (upper bits dropped). IO_BASE-1 is RAM; IO_BASE is I/O.
- A write leaves memReadData unchanged.

## Timing
- Request sampled in IDLE at cycle T.
- RAM read or write: memReady at T+2; read data valid from T+2 until the next completed read.
- I/O access: memReady at T+2+IO_WAIT. The LED/counter update takes effect at the edge ending the IO_WAIT-0 cycle, so leds shows the new value in the memReady cycle.
- Back-to-back different requests (HOLD -> IDLE -> accept): minimum 4-cycle spacing for RAM.
- Switch value is 2 cycles stale, plus access latency.
- Reset values: state IDLE; memReadData 0, memReady 0, leds 0, ioError 0; counter 0; synchronizers 0; ramEnable/ramWriteEnable 0.
- Reset mid-access aborts with no memReady and no pending I/O write. A RAM write already issued in cycle T is not undone.

## Structure
- Shared package `mem_map_pkg`: IO_BASE, I/O offsets (LED=0, SW=1, CNT=2), state encoding, data width 16.
- Sub-module `mmio_regs`: LED register, switch synchronizer, cycle counter, offset decode, ioError. It receives a one-cycle access strobe plus offset/we/data and returns read data combinationally.
- Top level holds the FSM, capture registers, wait counter and RAM port drive.

## Test plan
- Reset, then hold memAEnabled=1, we=1, addr 16'h0010, data 16'hBEEF -> ramWriteEnable high only in cycle T, memReady at T+2. Hold for 5 cycles -> no second write.
- Read 16'h0010 after the above -> memReady at T+2 with memReadData=16'hBEEF, held while the request is held.
- Write 16'hFF00 data 16'h00A5 with IO_WAIT=2 -> memReady at T+4, leds=16'h00A5. Reading FF00 back returns 16'h00A5.
- switches=16'h1234, read FF01 -> 16'h1234. Write FF01 -> ioError=1 and stays 1, leds unchanged.
- Write FF02 at any count -> a later read returns the elapsed cycles since the clear. Run 65536 cycles -> counter wraps to the same value.
- Assert reset during IO_WAIT of an LED write -> no memReady, leds=0, state IDLE. Address 16'hFEFF with RAM_ADDR_WIDTH=10 -> RAM access at ramAddr 10'h2FF.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM encoding for the port-A responder.
package mem_map_pkg;

    localparam int          DATA_W      = 16;
    localparam logic [15:0] DEF_IO_BASE = 16'hFF00;

    // I/O register offsets relative to the I/O base address
    localparam logic [15:0] OFF_LED = 16'd0;
    localparam logic [15:0] OFF_SW  = 16'd1;
    localparam logic [15:0] OFF_CNT = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_IO_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    // True when the word address falls in the memory-mapped I/O window
    function automatic logic is_io_addr(input logic [15:0] addr, input logic [15:0] base);
        return addr >= base;
    endfunction

endpackage

// File: rtl/mmio_regs.sv
// I/O register block: LEDs, synchronized switches, free-running cycle counter.
// Accesses arrive as a single-cycle strobe; read data is combinational.
module mmio_regs
    import mem_map_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_acc,
    input  logic [15:0]       i_off,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_sw,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_leds,
    output logic              o_io_error
);

    logic [DATA_W-1:0] r_sw_meta;
    logic [DATA_W-1:0] r_sw_sync;
    logic [DATA_W-1:0] r_leds;
    logic [DATA_W-1:0] r_cnt;
    logic              r_io_error;
    logic              w_wr;

    assign w_wr = i_acc && i_we;

    // Two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= i_sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // LED register, written only through its own offset
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_leds <= '0;
        else if (w_wr && i_off == OFF_LED)
            r_leds <= i_wdata;
    end

    // Cycle counter; a write clears it and wins over the increment
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_wr && i_off == OFF_CNT)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    // Sticky error on writes to the switch port or unmapped offsets
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_io_error <= 1'b0;
        else if (w_wr && i_off != OFF_LED && i_off != OFF_CNT)
            r_io_error <= 1'b1;
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        o_rdata = '0;
        case (i_off)
            OFF_LED: o_rdata = r_leds;
            OFF_SW:  o_rdata = r_sw_sync;
            OFF_CNT: o_rdata = r_cnt;
            default: o_rdata = '0;
        endcase
    end

    assign o_leds     = r_leds;
    assign o_io_error = r_io_error;

endmodule

// File: rtl/data_mem_responder.sv
// Port-A memory responder: decodes RAM vs I/O, drives the block RAM,
// sequences I/O wait states and returns read data with a one-cycle ready.
module data_mem_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter logic [15:0] IO_BASE        = DEF_IO_BASE,
    parameter int          IO_WAIT        = 2
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      memAEnabled,
    input  logic                      memAWriteEnabled,
    input  logic [15:0]               memAddr,
    input  logic [DATA_W-1:0]         memWriteData,
    output logic [DATA_W-1:0]         memReadData,
    output logic                      memReady,
    output logic                      ramEnable,
    output logic                      ramWriteEnable,
    output logic [RAM_ADDR_WIDTH-1:0] ramAddr,
    output logic [DATA_W-1:0]         ramWriteData,
    input  logic [DATA_W-1:0]         ramReadData,
    input  logic [DATA_W-1:0]         switches,
    output logic [DATA_W-1:0]         leds,
    output logic                      ioError
);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wait;
    logic [DATA_W-1:0] r_rdata;

    logic              w_is_io;
    logic              w_accept;
    logic              w_io_go;
    logic [15:0]       w_io_off;
    logic [DATA_W-1:0] w_io_rdata;

    assign w_is_io  = is_io_addr(memAddr, IO_BASE);
    assign w_accept = (r_state == ST_IDLE) && memAEnabled;
    assign w_io_go  = (r_state == ST_IO_WAIT) && (r_wait == 4'd0);
    assign w_io_off = r_addr - IO_BASE;

    mmio_regs u_mmio (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_acc      (w_io_go),
        .i_off      (w_io_off),
        .i_we       (r_we),
        .i_wdata    (r_wdata),
        .i_sw       (switches),
        .o_rdata    (w_io_rdata),
        .o_leds     (leds),
        .o_io_error (ioError)
    );

    // State register; reset drops any in-flight access
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and RAM port drive; the RAM is strobed in the accept cycle
    always_comb begin
        w_next         = r_state;
        memReady       = 1'b0;
        ramEnable      = 1'b0;
        ramWriteEnable = 1'b0;
        ramAddr        = memAddr[RAM_ADDR_WIDTH-1:0];
        ramWriteData   = memWriteData;
        case (r_state)
            ST_IDLE: begin
                if (memAEnabled) begin
                    w_next = w_is_io ? ST_IO_WAIT : ST_RAM_ACC;
                    if (!w_is_io && !reset) begin
                        ramEnable      = 1'b1;
                        ramWriteEnable = memAWriteEnabled;
                    end
                end
            end
            ST_RAM_ACC: w_next = ST_DONE;
            ST_IO_WAIT: if (r_wait == 4'd0) w_next = ST_DONE;
            ST_DONE: begin
                memReady = 1'b1;
                w_next   = ST_HOLD;
            end
            ST_HOLD: begin
                // A still-held identical request is the one already served
                if (!memAEnabled || memAddr != r_addr || memAWriteEnabled != r_we)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, wait countdown and read-data register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= memAddr;
                r_we    <= memAWriteEnabled;
                r_wdata <= memWriteData;
                r_wait  <= 4'(IO_WAIT);
            end
            if (r_state == ST_IO_WAIT && r_wait != 4'd0)
                r_wait <= r_wait - 4'd1;
            if (r_state == ST_RAM_ACC && !r_we)
                r_rdata <= ramReadData;
            if (w_io_go && !r_we)
                r_rdata <= w_io_rdata;
        end
    end

    assign memReadData = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a transaction-level reference model.
module tb_data_mem_responder;

    localparam int          AW   = 10;
    localparam int          IOW  = 2;
    localparam logic [15:0] BASE = 16'hFF00;

    logic          clock = 1'b0;
    logic          reset;
    logic          memAEnabled, memAWriteEnabled;
    logic [15:0]   memAddr, memWriteData, memReadData;
    logic          memReady, ramEnable, ramWriteEnable;
    logic [AW-1:0] ramAddr;
    logic [15:0]   ramWriteData, ramReadData, switches, leds;
    logic          ioError;

    data_mem_responder #(.RAM_ADDR_WIDTH(AW), .IO_BASE(BASE), .IO_WAIT(IOW)) dut (
        .clock(clock), .reset(reset),
        .memAEnabled(memAEnabled), .memAWriteEnabled(memAWriteEnabled),
        .memAddr(memAddr), .memWriteData(memWriteData),
        .memReadData(memReadData), .memReady(memReady),
        .ramEnable(ramEnable), .ramWriteEnable(ramWriteEnable),
        .ramAddr(ramAddr), .ramWriteData(ramWriteData), .ramReadData(ramReadData),
        .switches(switches), .leds(leds), .ioError(ioError)
    );

    always #5 clock = ~clock;

    // Count of rising edges seen so far; sampled on falling edges
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Block RAM stand-in
    logic [15:0] tb_ram [1024];
    always @(posedge clock)
        if (ramEnable) begin
            if (ramWriteEnable) tb_ram[ramAddr] <= ramWriteData;
            else                ramReadData     <= tb_ram[ramAddr];
        end

    // Reference model state
    logic [15:0] m_ram [1024];
    logic [15:0] m_leds, m_rd;
    logic        m_err;
    int          zc;      // rising edge after which the counter reads 0

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply one request, check timing and results, hold it, then release
    task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input logic [15:0] sw);
        bit          io;
        int          lat;
        logic [15:0] off;
        io  = (a >= BASE);
        lat = io ? 2 + IOW : 2;
        off = a - BASE;
        @(negedge clock);
        memAEnabled = 1'b0;
        switches    = sw;
        repeat (3) @(negedge clock);
        memAEnabled = 1'b1; memAWriteEnabled = we; memAddr = a; memWriteData = d;
        #1;
        chk("ram_en", ramEnable, !io);
        if (!io) begin
            chk("ram_we",   ramWriteEnable, we);
            chk("ram_addr", ramAddr, a % 1024);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            chk("ready", memReady, k == lat);
            if (k < lat) chk("ram_en_busy", ramEnable, 0);
        end
        if (!io) begin
            if (we) m_ram[a % 1024] = d;
            else    m_rd = m_ram[a % 1024];
        end else if (we) begin
            if (off == 16'd0)      m_leds = d;
            else if (off == 16'd2) zc = cyc;
            else                   m_err = 1'b1;
        end else begin
            if (off == 16'd0)      m_rd = m_leds;
            else if (off == 16'd1) m_rd = sw;
            else if (off == 16'd2) m_rd = 16'(cyc - 1 - zc);
            else                   m_rd = 16'h0000;
        end
        chk("rdata", memReadData, m_rd);
        chk("leds", leds, m_leds);
        chk("ioerr", ioError, m_err);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            chk("hold_ready",  memReady, 0);
            chk("hold_ram_en", ramEnable, 0);
            chk("hold_rdata",  memReadData, m_rd);
        end
        memAEnabled = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; memAEnabled = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        zc = cyc;
        reset = 1'b0;
        m_leds = '0; m_err = 1'b0; m_rd = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          sel;
        for (int i = 0; i < 1024; i++) begin
            tb_ram[i] = '0;
            m_ram[i]  = '0;
        end
        reset = 1'b1; memAEnabled = 1'b0; memAWriteEnabled = 1'b0;
        memAddr = '0; memWriteData = '0; switches = '0;
        do_reset();
        #1;
        chk("rst_rdata", memReadData, 16'h0000);
        chk("rst_ready", memReady, 0);
        chk("rst_leds",  leds, 16'h0000);
        chk("rst_ioerr", ioError, 0);
        chk("rst_ram_en", ramEnable, 0);

        // Directed scenarios
        access(1, 16'h0010, 16'hBEEF, 5, 16'h0000);
        access(0, 16'h0010, 16'h0000, 3, 16'h0000);
        chk("rd_beef", memReadData, 16'hBEEF);
        access(1, 16'hFF00, 16'h00A5, 0, 16'h0000);
        chk("leds_a5", leds, 16'h00A5);
        access(0, 16'hFF00, 16'h0000, 1, 16'h0000);
        chk("rd_a5", memReadData, 16'h00A5);
        access(0, 16'hFF01, 16'h0000, 1, 16'h1234);
        chk("rd_sw", memReadData, 16'h1234);
        access(1, 16'hFF01, 16'h5555, 2, 16'h1234);
        chk("ioerr_set", ioError, 1);
        chk("leds_keep", leds, 16'h00A5);
        access(1, 16'hFEFF, 16'hC0DE, 0, 16'h0000);
        access(0, 16'h02FF, 16'h0000, 0, 16'h0000);
        chk("alias", memReadData, 16'hC0DE);
        access(1, 16'hFF02, 16'h0000, 0, 16'h0000);
        repeat ($urandom_range(1, 40)) @(negedge clock);
        access(0, 16'hFF02, 16'h0000, 0, 16'h0000);

        // Held request changes address: served afresh after HOLD -> IDLE
        access(1, 16'h0011, 16'h7777, 0, 16'h0000);
        access(0, 16'h0010, 16'h0000, 1, 16'h0000);
        memAEnabled = 1'b1; memAddr = 16'h0011; memAWriteEnabled = 1'b0;
        @(negedge clock);
        chk("b2b_accept", ramEnable, 1);
        chk("b2b_addr", ramAddr, 16'h0011);
        @(negedge clock);
        chk("b2b_ready_early", memReady, 0);
        @(negedge clock);
        chk("b2b_ready", memReady, 1);
        chk("b2b_rdata", memReadData, 16'h7777);
        m_rd = 16'h7777;
        memAEnabled = 1'b0;

        // Reset in the middle of an LED write's wait states
        @(negedge clock);
        repeat (3) @(negedge clock);
        memAEnabled = 1'b1; memAWriteEnabled = 1'b1; memAddr = 16'hFF00; memWriteData = 16'h1357;
        repeat (2) @(negedge clock);
        reset = 1'b1; memAEnabled = 1'b0;
        @(negedge clock);
        zc = cyc;
        reset = 1'b0;
        m_leds = '0; m_err = 1'b0; m_rd = '0;
        chk("rst_mid_ready", memReady, 0);
        chk("rst_mid_leds",  leds, 16'h0000);
        chk("rst_mid_ioerr", ioError, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rst_mid_quiet", memReady, 0);
            chk("rst_mid_leds2", leds, 16'h0000);
        end
        access(0, 16'hFF00, 16'h0000, 0, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 16'($urandom_range(0, 31));
                1:       a = 16'($urandom_range(0, 16'hFEFF));
                default: a = BASE + 16'($urandom_range(0, 4));
            endcase
            access(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3), 16'($urandom));
        end

        // Counter wrap: a full 2^16-cycle gap
        access(0, 16'hFF02, 16'h0000, 0, 16'h0000);
        repeat (65536) @(negedge clock);
        access(0, 16'hFF02, 16'h0000, 0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
